// File: rtl/cronometro_teclado_if.sv
// Bundle of the controller-facing and keypad-facing signals of the stopwatch core.
interface cronometro_teclado_if;
  logic        runner;
  logic        modo;
  logic        pset;
  logic [4:1]  lin;
  logic [4:1]  col;
  logic        clkout;
  logic [13:0] num_at;
  logic [13:0] num_set;

  // Controller / keypad side: drives strobes and rows, observes the core.
  modport master (
    output runner, modo, pset, lin,
    input  col, clkout, num_at, num_set
  );

  // Stopwatch core side.
  modport slave (
    input  runner, modo, pset, lin,
    output col, clkout, num_at, num_set
  );
endinterface

// File: rtl/cronometro_teclado.sv
// Stopwatch core: state-clock divider, count tick, 4x4 keypad scanner with
// debounced decimal entry, and a 0..9999 up/down counter with settable limit.
module cronometro_teclado #(
  parameter int STATE_DIV  = 25_000_000,
  parameter int TICK_DIV   = 50_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int DEB_CYCLES = 500_000
) (
  input logic clk,
  input logic reset,
  cronometro_teclado_if.slave bus
);

  localparam int SD_W = (STATE_DIV > 1) ? $clog2(STATE_DIV) : 1;
  localparam int TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W = $clog2(DEB_CYCLES + 1);

  localparam logic [SD_W-1:0] SD_MAX = SD_W'(STATE_DIV - 1);
  localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_SAT = DB_W'(DEB_CYCLES);
  localparam logic [13:0]     MAX_VAL = 14'd9999;

  typedef enum logic {K_ARMED = 1'b0, K_DISARMED = 1'b1} kst_t;

  // Clamp a 14-bit value into the displayable 0..9999 range.
  function automatic logic [13:0] sat_9999(input logic [13:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // Shift a decimal digit into a value, keeping only the last four digits.
  function automatic logic [13:0] append_digit(input logic [13:0] v, input logic [3:0] d);
    logic [17:0] full;
    full = 18'(v) * 18'd10 + 18'(d);
    return 14'(full % 18'd10000);
  endfunction

  logic [SD_W-1:0] state_cnt_q, state_cnt_d;
  logic            clkout_q, clkout_d;
  logic [TK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [SC_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [4:1]      col_q, col_d;
  logic [4:1]      pat_q, pat_d;
  logic [DB_W-1:0] run_q, run_d;
  logic            lin_idle, stable;
  kst_t            kst_q, kst_d;
  logic            key_evt;
  logic [1:0]      row_idx, col_idx;
  logic            key_is_dig, key_is_star;
  logic [3:0]      key_dig;
  logic [13:0]     num_set_q, num_set_d;
  logic [13:0]     limite_q, limite_d;
  logic [13:0]     num_at_q, num_at_d;
  logic            modo_q, modo_d;

  // State-clock divider and free-running count tick.
  always_comb begin
    state_cnt_d = state_cnt_q + SD_W'(1);
    clkout_d    = clkout_q;
    if (state_cnt_q == SD_MAX) begin
      state_cnt_d = '0;
      clkout_d    = ~clkout_q;
    end
    tick       = (tick_cnt_q == TK_MAX);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TK_W'(1);
  end

  // Column rotation while idle, and run length of the current row pattern.
  always_comb begin
    lin_idle   = &bus.lin;
    scan_cnt_d = scan_cnt_q;
    col_d      = col_q;
    if (lin_idle) begin
      if (scan_cnt_q == SC_MAX) begin
        scan_cnt_d = '0;
        col_d      = {col_q[3:1], col_q[4]};
      end else begin
        scan_cnt_d = scan_cnt_q + SC_W'(1);
      end
    end
    pat_d = bus.lin;
    if (bus.lin != pat_q) begin
      run_d = DB_W'(1);
    end else if (run_q == DB_SAT) begin
      run_d = run_q;
    end else begin
      run_d = run_q + DB_W'(1);
    end
    stable = (run_d == DB_SAT);
  end

  // Press/release arming FSM: next state.
  always_comb begin
    kst_d = kst_q;
    unique case (kst_q)
      K_ARMED:    if (!lin_idle && stable) kst_d = K_DISARMED;
      K_DISARMED: if (lin_idle && stable)  kst_d = K_ARMED;
      default:    kst_d = K_ARMED;
    endcase
  end

  // Press/release arming FSM: one-cycle key event on an accepted press.
  always_comb begin
    key_evt = (kst_q == K_ARMED) && !lin_idle && stable;
  end

  // Key decode from lowest low row and the active column.
  always_comb begin
    if (!bus.lin[1])      row_idx = 2'd0;
    else if (!bus.lin[2]) row_idx = 2'd1;
    else if (!bus.lin[3]) row_idx = 2'd2;
    else                  row_idx = 2'd3;
    case (col_q)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase
    key_is_dig  = 1'b0;
    key_is_star = 1'b0;
    key_dig     = 4'd0;
    if (row_idx != 2'd3) begin
      if (col_idx != 2'd3) begin
        key_is_dig = 1'b1;
        key_dig    = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
      end
    end else if (col_idx == 2'd0) begin
      key_is_star = 1'b1;
    end else if (col_idx == 2'd1) begin
      key_is_dig = 1'b1;
    end
  end

  // Entry register, limit tracking and the up/down counter.
  always_comb begin
    num_set_d = num_set_q;
    if (key_evt && bus.pset) begin
      if (key_is_dig)       num_set_d = append_digit(num_set_q, key_dig);
      else if (key_is_star) num_set_d = '0;
    end
    limite_d = bus.pset ? sat_9999(num_set_q) : limite_q;
    modo_d   = bus.modo;
    num_at_d = num_at_q;
    if (bus.modo != modo_q) begin
      num_at_d = bus.modo ? limite_q : '0;
    end else if (tick && bus.runner) begin
      if (!bus.modo) begin
        if (limite_q == '0)           num_at_d = (num_at_q >= MAX_VAL) ? '0 : num_at_q + 14'd1;
        else if (num_at_q < limite_q) num_at_d = num_at_q + 14'd1;
      end else if (num_at_q != '0) begin
        num_at_d = num_at_q - 14'd1;
      end
    end
  end

  // Arming FSM state register.
  always_ff @(posedge clk) begin
    if (reset) kst_q <= K_ARMED;
    else       kst_q <= kst_d;
  end

  // Datapath and divider registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_cnt_q <= '0;
      clkout_q    <= 1'b0;
      tick_cnt_q  <= '0;
      scan_cnt_q  <= '0;
      col_q       <= 4'b1110;
      pat_q       <= 4'b1111;
      run_q       <= '0;
      num_set_q   <= '0;
      limite_q    <= '0;
      num_at_q    <= '0;
      modo_q      <= bus.modo;
    end else begin
      state_cnt_q <= state_cnt_d;
      clkout_q    <= clkout_d;
      tick_cnt_q  <= tick_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      run_q       <= run_d;
      num_set_q   <= num_set_d;
      limite_q    <= limite_d;
      num_at_q    <= num_at_d;
      modo_q      <= modo_d;
    end
  end

  assign bus.col     = col_q;
  assign bus.clkout  = clkout_q;
  assign bus.num_at  = num_at_q;
  assign bus.num_set = num_set_q;

endmodule

// File: tb/tb_cronometro_teclado.sv
// Bench for cronometro_teclado: keypad matrix model, behavioural reference
// model feeding a scoreboard queue, and a negedge monitor that compares.
module tb_cronometro_teclado;
  localparam int SD  = 2;
  localparam int TD  = 4;
  localparam int SCD = 2;
  localparam int DB  = 3;

  logic clk = 1'b0;
  logic reset;
  cronometro_teclado_if ifc();

  cronometro_teclado #(.STATE_DIV(SD), .TICK_DIV(TD), .SCAN_DIV(SCD), .DEB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .bus(ifc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [13:0] at; logic [13:0] set; logic [3:0] col; logic ck; } exp_t;
  typedef struct { string nm; logic [31:0] act; logic [31:0] exp; } chk_t;
  exp_t sbq[$];
  chk_t chq[$];
  int vectors = 0;
  int miscompares = 0;

  logic [15:0] pressed;
  string keymap = "123A456B789C*0#D";
  int m_n, m_at, m_set, m_lim, m_idle, m_run, m_col;
  bit m_armed;
  logic m_modo_q;
  logic [3:0] m_last;

  function automatic logic [3:0] col_code(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (c - 1));
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Keypad matrix: a row is pulled low when a pressed key sits in the active column.
  initial begin
    ifc.lin = 4'hF;
    m_col = 1;
    forever begin
      @(negedge clk);
      for (int r = 1; r <= 4; r++) begin
        ifc.lin[r] = ~pressed[(r - 1) * 4 + (m_col - 1)];
      end
    end
  end

  // Reference model: one expected output set per clock edge.
  initial begin
    forever begin
      logic [3:0] l;
      int ev_col, row, nat, nset, nlim;
      bit stable, ev;
      byte ch;
      @(posedge clk);
      l = ifc.lin;
      if (reset) begin
        m_n = 0; m_at = 0; m_set = 0; m_lim = 0; m_modo_q = ifc.modo;
        m_idle = 0; m_run = 0; m_last = 4'hF; m_armed = 1'b1;
      end else begin
        m_n++;
        m_run  = (l == m_last) ? m_run + 1 : 1;
        m_last = l;
        stable = (m_run >= DB);
        ev = 1'b0;
        if (m_armed && l != 4'hF && stable) begin
          ev = 1'b1;
          m_armed = 1'b0;
        end else if (!m_armed && l == 4'hF && stable) begin
          m_armed = 1'b1;
        end
        ev_col = (m_idle / SCD) % 4 + 1;
        if (l == 4'hF) m_idle++;
        nset = m_set;
        if (ev && ifc.pset) begin
          row = !l[0] ? 1 : !l[1] ? 2 : !l[2] ? 3 : 4;
          ch  = keymap[(row - 1) * 4 + ev_col - 1];
          if (ch >= 8'h30 && ch <= 8'h39) nset = (m_set * 10 + (ch - 8'h30)) % 10000;
          else if (ch == 8'h2A)           nset = 0;
        end
        nat = m_at;
        if (ifc.modo != m_modo_q) begin
          nat = ifc.modo ? m_lim : 0;
        end else if (ifc.runner && (m_n % TD) == 0) begin
          if (!ifc.modo) begin
            if (m_lim == 0)         nat = (m_at + 1) % 10000;
            else if (m_at < m_lim)  nat = m_at + 1;
          end else if (m_at > 0) begin
            nat = m_at - 1;
          end
        end
        nlim = ifc.pset ? ((m_set > 9999) ? 9999 : m_set) : m_lim;
        m_at = nat; m_set = nset; m_lim = nlim; m_modo_q = ifc.modo;
      end
      m_col = (m_idle / SCD) % 4 + 1;
      sbq.push_back('{at: 14'(m_at), set: 14'(m_set), col: col_code(m_col), ck: ((m_n / SD) % 2) == 1});
    end
  end

  // Monitor: pops expectations and compares against the DUT away from the edge.
  initial begin
    forever begin
      exp_t e;
      chk_t c;
      @(negedge clk);
      while (chq.size() > 0) begin
        c = chq.pop_front();
        cmp(c.nm, c.act, c.exp);
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp("num_at", 32'(ifc.num_at), 32'(e.at));
        cmp("num_set", 32'(ifc.num_set), 32'(e.set));
        cmp("col", 32'(ifc.col), 32'(e.col));
        cmp("clkout", 32'(ifc.clkout), 32'(e.ck));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chq.push_back('{nm: nm, act: act, exp: exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] rows, input int c, input int hold);
    int guard;
    guard = 0;
    while (m_col != c && guard < 40) begin
      step(1);
      guard++;
    end
    chk("press_col_wait", 32'(m_col), 32'(c));
    for (int r = 1; r <= 4; r++) if (rows[r - 1]) pressed[(r - 1) * 4 + c - 1] = 1'b1;
    step(hold);
  endtask

  task automatic release_keys(input int hold);
    pressed = '0;
    step(hold);
  endtask

  task automatic key(input int row, input int c);
    press(4'(1 << (row - 1)), c, 3);
    release_keys(3);
  endtask

  task automatic wait_at(input int v, input int lim);
    int g;
    g = 0;
    while (ifc.num_at != 14'(v) && g < lim) begin
      step(1);
      g++;
    end
    chk("wait_num_at", 32'(ifc.num_at), 32'(v));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    pressed = '0;
    ifc.runner = 1'b0; ifc.modo = 1'b0; ifc.pset = 1'b0;
    reset = 1'b1;
    step(2);
    chk("rst_num_at", 32'(ifc.num_at), 0);
    chk("rst_num_set", 32'(ifc.num_set), 0);
    chk("rst_col", 32'(ifc.col), 32'(4'b1110));
    chk("rst_clkout", 32'(ifc.clkout), 0);
    reset = 1'b0;
    ifc.runner = 1'b1;
    step(2);
    chk("clkout_hi", 32'(ifc.clkout), 1);
    chk("at_n2", 32'(ifc.num_at), 0);
    step(2);
    chk("clkout_lo", 32'(ifc.clkout), 0);
    chk("at_n4", 32'(ifc.num_at), 1);
    step(36);
    chk("at_40cyc", 32'(ifc.num_at), 10);
    step(39956);
    chk("at_9999", 32'(ifc.num_at), 9999);
    step(4);
    chk("at_wrap", 32'(ifc.num_at), 0);
    ifc.runner = 1'b0;

    ifc.pset = 1'b1;
    key(1, 1); key(1, 2); key(1, 3); key(2, 1); key(2, 2);
    chk("set_2345", 32'(ifc.num_set), 2345);
    ifc.pset = 1'b0;
    key(3, 1);
    chk("set_locked", 32'(ifc.num_set), 2345);
    ifc.pset = 1'b1;
    key(4, 1);
    chk("set_star", 32'(ifc.num_set), 0);
    key(1, 3);
    step(2);
    ifc.pset = 1'b0;
    chk("set_3", 32'(ifc.num_set), 3);

    ifc.runner = 1'b1;
    step(40);
    chk("hold_limit", 32'(ifc.num_at), 3);
    ifc.modo = 1'b1;
    step(1);
    chk("reload_lim", 32'(ifc.num_at), 3);
    ifc.modo = 1'b0;
    step(1);
    chk("reload_zero", 32'(ifc.num_at), 0);
    wait_at(2, 40);
    ifc.modo = 1'b1;
    step(1);
    chk("down_reload", 32'(ifc.num_at), 3);
    wait_at(1, 40);
    ifc.runner = 1'b0;
    step(20);
    chk("frozen", 32'(ifc.num_at), 1);
    ifc.runner = 1'b1;
    step(40);
    chk("hold_zero", 32'(ifc.num_at), 0);

    ifc.pset = 1'b1;
    key(4, 1);
    press(4'b0010, 2, 2);
    release_keys(1);
    press(4'b0010, 2, 3);
    release_keys(3);
    chk("bounce_once", 32'(ifc.num_set), 5);
    press(4'b0011, 1, 3);
    release_keys(3);
    chk("multi_row", 32'(ifc.num_set), 51);

    for (int i = 0; i < 150; i++) begin
      ifc.pset   = 1'($urandom_range(0, 1));
      ifc.runner = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) ifc.modo = ~ifc.modo;
      press(4'($urandom_range(1, 15)), $urandom_range(1, 4), $urandom_range(1, 5));
      release_keys($urandom_range(1, 5));
    end

    ifc.pset = 1'b1;
    press(4'b0100, 3, 2);
    reset = 1'b1;
    step(1);
    chk("midrst_num_at", 32'(ifc.num_at), 0);
    chk("midrst_num_set", 32'(ifc.num_set), 0);
    chk("midrst_col", 32'(ifc.col), 32'(4'b1110));
    chk("midrst_clkout", 32'(ifc.clkout), 0);
    pressed = '0;
    reset = 1'b0;
    step(8);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cronometro_teclado.md
Name: cronometro_teclado

Overview:
- Stopwatch/timer core: clock-divider tick generator, 4x4 matrix-keypad scanner with decimal entry, and a 0..9999 BCD-range up/down counter with a settable limit.
- Sits between the top-level control FSM (drives run/mode/set strobes, consumes the divided state clock) and the 7-segment decoder (consumes num_at / num_set).

Parameters:
- STATE_DIV, 25_000_000, half-period of clkout in clk cycles (clkout period = 2*STATE_DIV).
- TICK_DIV, 50_000, clk cycles per count step (count_tick period).
- SCAN_DIV, 50_000, clk cycles each keypad column stays active while no key is pressed.
- DEB_CYCLES, 500_000, clk cycles a line pattern must stay stable to accept a press or a release.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- runner  in  1  1 = counting enabled.
- modo  in  1  0 = count up, 1 = count down.
- pset  in  1  1 = keypad entry enabled, limit tracks num_set.
- lin  in  4 [4:1]  keypad row inputs, active-low (pulled up).
- col  out  4 [4:1]  keypad column drives, one-hot active-low.
- clkout  out  1  divided square-wave state clock.
- num_at  out  14  current counter value, 0..9999.
- num_set  out  14  keypad-entered value, 0..9999.

Behaviour:
- Reset: clkout=0, divider counters=0, col=4'b1110, scan idle, num_set=0, limite=0, num_at = (modo ? 0 : 0) = 0, modo_q=modo.
- clkout: counter 0..STATE_DIV-1; clkout toggles in the cycle the counter wraps.
- count_tick: internal one-cycle pulse every TICK_DIV cycles (counter 0..TICK_DIV-1, pulse at TICK_DIV-1). Free-running, independent of runner.
- Limit: while pset=1, limite <= min(num_set, 9999) every cycle; holds when pset=0.
- Mode change: modo_q registers modo; if modo != modo_q, next cycle num_at <= modo ? limite : 0. This reload has priority over counting.
- Up (modo=0), on count_tick with runner=1: limite=0 → free-run 0..9999, 9999 wraps to 0. limite>0 → increment until num_at==limite, then hold.
- Down (modo=1), on count_tick with runner=1: decrement to 0, then hold at 0; no wrap.
- runner=0: num_at holds.
- Keypad scan: while lin==4'b1111, active column rotates col[1]→col[2]→col[3]→col[4]→col[1] every SCAN_DIV cycles. While any lin bit is low, rotation freezes on the current column.
- Press acceptance: lin pattern != 1111 and unchanged for DEB_CYCLES consecutive cycles → one key event, then disarm. Rearm only after lin==1111 for DEB_CYCLES consecutive cycles.
- Multiple low rows: lowest-index row wins.
- Key map (row=lin index, column=active col index):
  - r1: 1 2 3 A
  - r2: 4 5 6 B
  - r3: 7 8 9 C
  - r4: * 0 # D
- Key event with pset=1:
  - digit d → num_set <= (num_set*10 + d) mod 10000 (keeps last four digits).
  - '*' → num_set <= 0.
  - A–D, '#' ignored.
- Key event with pset=0: ignored; num_set holds.
- Reset mid-operation: all state returns to reset values on the next edge; in-progress debounce is discarded.
- All arithmetic unsigned 14-bit; num_at and num_set never exceed 9999.

Test Plan (STATE_DIV=2, TICK_DIV=4, SCAN_DIV=2, DEB_CYCLES=3):
- Reset held 2 cycles → num_at=0, num_set=0, col=1110, clkout=0; after release, clkout toggles every 2 cycles.
- modo=0, runner=1, limite=0: 40 cycles → num_at=10. Preload path to 9999, one more tick → 0.
- pset=1, press keys 1,2,3,4,5 (each held ≥3 cycles, released ≥3 cycles) → num_set=2345. Press '*' → num_set=0. With pset=0, press 7 → unchanged.
- num_set=3, pset=1 then 0, modo=0, runner=1 → num_at counts 0,1,2,3 and holds at 3 for further ticks.
- From up mode at num_at=2, toggle modo to 1 → num_at=3 (limite) next cycle, then 2,1,0 on ticks, holds at 0. runner=0 mid-count → value frozen.
- Key bounce: lin low for 2 cycles, high, low again 3 cycles → exactly one digit accepted. Rows 1 and 2 low on col[1] → '1' entered.
